// File: rtl/uart_word_loader_if.sv
// Signal bundle between the UART word loader and its surroundings (UART, memory, CPU debug).
// master = the loader itself, slave = the environment driving it.
interface uart_word_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // Handshakes: a byte is taken when rx_rdy and clr_rx_rdy are both high in one cycle;
  // a word is queued when tx_push is high and txq_full is low in that cycle; every trmt
  // pulse is answered by exactly one tx_done pulse before the next trmt may appear.
  logic              debug;
  logic [ADDR_W-1:0] base_addr;
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              clr_rx_rdy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] tx_word;
  logic              tx_push;
  logic              txq_full;
  logic              tx_ovf;
  logic              trmt;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic              tx_busy;
  logic              rx_state_dbg;
  logic [1:0]        tx_state_dbg;

  modport master (
    input  debug, base_addr, rx_rdy, rx_data, tx_word, tx_push, tx_done,
    output clr_rx_rdy, wr_en, wr_addr, wr_data, txq_full, tx_ovf, trmt, tx_data, tx_busy,
    output rx_state_dbg, tx_state_dbg
  );

  modport slave (
    output debug, base_addr, rx_rdy, rx_data, tx_word, tx_push, tx_done,
    input  clr_rx_rdy, wr_en, wr_addr, wr_data, txq_full, tx_ovf, trmt, tx_data, tx_busy,
    input  rx_state_dbg, tx_state_dbg
  );
endinterface

// File: rtl/uart_word_loader.sv
// UART boot/debug loader: packs RX bytes into words written at incrementing addresses,
// and drains a small debug word FIFO to the UART one byte at a time.
module uart_word_loader #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter bit RX_MSB_FIRST = 1'b1,
  parameter bit TX_LSB_FIRST = 1'b1,
  parameter int TXQ_DEPTH    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_word_loader_if.master  bus
);
  localparam int WORD_BYTES = DATA_W / 8;
  localparam int CNT_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int PTR_W      = $clog2(TXQ_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_BYTES - 1);

  typedef enum logic {RX_COLLECT = 1'b0, RX_COMMIT = 1'b1} rx_state_e;
  typedef enum logic [1:0] {TX_STEADY = 2'd0, TX_START = 2'd1, TX_WAIT = 2'd2} tx_state_e;

  rx_state_e         rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              clr_rx_rdy, wr_en;

  logic [DATA_W-1:0] mem_q [TXQ_DEPTH];
  logic [DATA_W-1:0] mem_d [TXQ_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic              full, empty, push_ok, pop;

  tx_state_e         tx_state_q, tx_state_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic              trmt;

  // RX side: debug low overrides everything and parks the loader at base_addr.
  always_comb begin
    rx_state_d = rx_state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    clr_rx_rdy = 1'b0;
    wr_en      = 1'b0;
    if (!bus.debug) begin
      rx_state_d = RX_COLLECT;
      byte_cnt_d = '0;
      wr_addr_d  = bus.base_addr;
    end else begin
      case (rx_state_q)
        RX_COLLECT: begin
          if (bus.rx_rdy) begin
            clr_rx_rdy = 1'b1;
            asm_d = RX_MSB_FIRST ? ((asm_q << 8) | DATA_W'(bus.rx_data))
                                 : ((asm_q >> 8) | (DATA_W'(bus.rx_data) << (DATA_W - 8)));
            if (byte_cnt_q == LAST_BYTE) rx_state_d = RX_COMMIT;
            else                         byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end
        RX_COMMIT: begin
          wr_en      = 1'b1;
          wr_data_d  = asm_q;
          wr_addr_d  = wr_addr_q + ADDR_W'(1);
          byte_cnt_d = '0;
          rx_state_d = RX_COLLECT;
        end
        default: rx_state_d = RX_COLLECT;
      endcase
    end
  end

  // FIFO pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push_ok = bus.tx_push && !full;
  assign pop     = (tx_state_q == TX_STEADY) && !empty;

  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q[PTR_W-1:0]] = bus.tx_word;
    wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
    tx_ovf_d = tx_ovf_q | (bus.tx_push & full);
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    trmt       = 1'b0;
    case (tx_state_q)
      TX_STEADY: begin
        if (!empty) begin
          tx_shift_d = mem_q[rd_ptr_q[PTR_W-1:0]];
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        trmt       = 1'b1;
        tx_state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (bus.tx_done) begin
          if (tx_cnt_q == LAST_BYTE) begin
            tx_state_d = TX_STEADY;
          end else begin
            tx_shift_d = TX_LSB_FIRST ? (tx_shift_q >> 8) : (tx_shift_q << 8);
            tx_cnt_d   = tx_cnt_q + CNT_W'(1);
            tx_state_d = TX_START;
          end
        end
      end
      default: tx_state_d = TX_STEADY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_COLLECT;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_ovf_q   <= 1'b0;
      tx_state_q <= TX_STEADY;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_ovf_q   <= tx_ovf_d;
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  // During the write strobe the freshly assembled word is shown; otherwise the last one written.
  assign bus.wr_data      = wr_en ? asm_q : wr_data_q;
  assign bus.wr_en        = wr_en;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.clr_rx_rdy   = clr_rx_rdy;
  assign bus.txq_full     = full;
  assign bus.tx_ovf       = tx_ovf_q;
  assign bus.trmt         = trmt;
  assign bus.tx_data      = TX_LSB_FIRST ? tx_shift_q[7:0] : tx_shift_q[DATA_W-1 -: 8];
  assign bus.tx_busy      = (tx_state_q != TX_STEADY);
  assign bus.rx_state_dbg = rx_state_q;
  assign bus.tx_state_dbg = tx_state_q;
endmodule
